// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the instruction-memory read handshake, owns the PC,
// loads the instruction register and holds the word valid until decode acknowledges it.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ir_load,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fault
);

  localparam int STEP_BITS = (PC_STEP > 1) ? $clog2(PC_STEP) : 0;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'((1 << STEP_BITS) - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC      = ADDR_WIDTH'(PC_STEP);
  localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    HOLD,
    FAULT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [DATA_WIDTH-1:0] ir_data_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      wait_cnt_inc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  go_fetch;
  logic                  timeout_hit;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign go_fetch        = enable && !stall;
  assign wait_cnt_inc    = wait_cnt + CNT_W'(1);
  assign timeout_hit     = (TIMEOUT != 0) && (wait_cnt_inc == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Redirect outranks both mem_ready in FETCH and instr_ack in HOLD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go_fetch) state_next = FETCH;
      end
      FETCH: begin
        if (redirect_valid)   state_next = FETCH;
        else if (mem_ready)   state_next = LOAD;
        else if (timeout_hit) state_next = FAULT;
      end
      LOAD: begin
        state_next = redirect_valid ? FETCH : HOLD;
      end
      HOLD: begin
        if (redirect_valid || instr_ack) state_next = go_fetch ? FETCH : IDLE;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req     = (state == FETCH);
    ir_load     = (state == LOAD);
    instr_valid = (state == HOLD);
    fault       = (state == FAULT);
    mem_addr    = pc;
    ir_data     = ir_data_q;
    instr_pc    = instr_pc_q;
  end

  // The wait counter is held at zero outside FETCH, so every entry into FETCH starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      instr_pc_q <= RESET_PC;
      ir_data_q  <= '0;
      wait_cnt   <= '0;
    end else begin
      if (state != FAULT && redirect_valid) begin
        pc <= redirect_target;
      end else if (state == LOAD) begin
        pc <= pc + PC_INC;
      end

      if (state == FETCH && mem_ready && !redirect_valid) begin
        ir_data_q  <= mem_rdata;
        instr_pc_q <= pc;
      end

      if (state != FETCH || redirect_valid) begin
        wait_cnt <= '0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scoreboard of expected IR loads plus directed
// checks of handshake, redirect, stall, wrap, reset and timeout behaviour.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ir_load;
  logic [31:0] ir_data;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] instr_pc;
  logic        fault;

  logic        t_enable;
  logic        t_redirect_valid;
  logic        t_mem_req;
  logic [31:0] t_mem_addr;
  logic        t_ir_load;
  logic [31:0] t_ir_data;
  logic        t_instr_valid;
  logic [31:0] t_instr_pc;
  logic        t_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks    = 0;
  int   errors    = 0;
  int   loadCount = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA000_0000 + {2'b00, addr[31:2]} + 32'd1;
  endfunction

  assign mem_rdata = memWord(mem_addr);

  fetch_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ir_load       (ir_load),
    .ir_data       (ir_data),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .instr_pc      (instr_pc),
    .fault         (fault)
  );

  fetch_sequencer #(.TIMEOUT(3)) dut_to (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (t_enable),
    .stall         (1'b0),
    .redirect_valid(t_redirect_valid),
    .redirect_pc   (32'h0000_0040),
    .mem_req       (t_mem_req),
    .mem_addr      (t_mem_addr),
    .mem_ready     (1'b0),
    .mem_rdata     (32'h1234_5678),
    .ir_load       (t_ir_load),
    .ir_data       (t_ir_data),
    .instr_valid   (t_instr_valid),
    .instr_ack     (1'b0),
    .instr_pc      (t_instr_pc),
    .fault         (t_fault)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs; a read accepted without redirect becomes an expected IR load.
  task automatic applyStimulus(input logic en, input logic st, input logic rdy, input logic ack,
                               input logic redir, input logic [31:0] rpc);
    enable         = en;
    stall          = st;
    mem_ready      = rdy;
    instr_ack      = ack;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (reset_n && mem_req && rdy && !redir) expQ.push_back('{pc: mem_addr, data: memWord(mem_addr)});
  endtask

  task automatic cycle(input logic en, input logic st, input logic rdy, input logic ack,
                       input logic redir, input logic [31:0] rpc);
    applyStimulus(en, st, rdy, ack, redir, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n          = 1'b0;
    enable           = 1'b0;
    stall            = 1'b0;
    mem_ready        = 1'b0;
    instr_ack        = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    t_enable         = 1'b0;
    t_redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_ir_load", ir_load, 0);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_ir_data", ir_data, 0);
    checkOutput("rst_t_fault", t_fault, 0);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin : sbMonitor
    exp_t e;
    if (reset_n && ir_load) begin
      loadCount++;
      checkOutput("sb_nonempty", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sb_ir_data", ir_data, e.data);
        checkOutput("sb_instr_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    int reqCycles;
    int loadsBefore;
    reset_n          = 1'b0;
    t_enable         = 1'b0;
    t_redirect_valid = 1'b0;
    doReset();

    // Zero-wait memory, ack in the same cycle as valid: one instruction every three cycles.
    for (int k = 0; k < 9; k++) begin
      cycle(1, 0, 1, 1, 0, 0);
      checkOutput("seq_mem_req", mem_req, (k % 3) == 0);
      checkOutput("seq_ir_load", ir_load, (k % 3) == 1);
      checkOutput("seq_instr_valid", instr_valid, (k % 3) == 2);
      if (k % 3 == 0) checkOutput("seq_mem_addr", mem_addr, 4 * (k / 3));
      if (k % 3 == 2) checkOutput("seq_instr_pc", instr_pc, 4 * (k / 3));
    end
    checkOutput("seq_sb_drained", expQ.size(), 0);
    doReset();

    // Timeout instance: three unanswered FETCH cycles, then a sticky fault.
    t_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      checkOutput("to_fault", t_fault, i >= 3);
      checkOutput("to_mem_req", t_mem_req, i < 3);
    end
    t_redirect_valid = 1'b1;
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    checkOutput("to_fault_sticky", t_fault, 1);
    checkOutput("to_redirect_ignored", t_mem_addr, 0);
    checkOutput("to_no_load", t_ir_load, 0);
    checkOutput("to_no_valid", t_instr_valid, 0);
    checkOutput("to_ir_data", t_ir_data, 0);
    checkOutput("to_instr_pc", t_instr_pc, 0);
    doReset();

    // Five wait states at 0x10 with the default timeout.
    cycle(0, 0, 0, 0, 1, 32'h10);
    checkOutput("dly_idle_addr", mem_addr, 32'h10);
    checkOutput("dly_idle_req", mem_req, 0);
    cycle(1, 0, 0, 0, 0, 0);
    reqCycles   = 0;
    loadsBefore = loadCount;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) reqCycles++;
      cycle(1, 0, i == 5, 0, 0, 0);
    end
    checkOutput("dly_req_cycles", reqCycles, 6);
    checkOutput("dly_load_count", loadCount - loadsBefore, 1);
    checkOutput("dly_fault", fault, 0);
    checkOutput("dly_valid", instr_valid, 1);
    checkOutput("dly_instr_pc", instr_pc, 32'h10);
    checkOutput("dly_ir_data", ir_data, memWord(32'h10));
    cycle(0, 0, 0, 1, 0, 0);
    checkOutput("dly_idle_after_ack", instr_valid, 0);
    checkOutput("dly_sb_drained", expQ.size(), 0);
    doReset();

    // Redirect in FETCH colliding with mem_ready: data dropped, target aligned.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 32'h103);
    checkOutput("rdf_mem_req", mem_req, 1);
    checkOutput("rdf_mem_addr", mem_addr, 32'h100);
    checkOutput("rdf_no_load", ir_load, 0);
    cycle(1, 0, 1, 0, 0, 0);
    checkOutput("rdf_load", ir_load, 1);
    checkOutput("rdf_ir_data", ir_data, memWord(32'h100));
    cycle(1, 0, 0, 0, 0, 0);
    checkOutput("rdf_valid", instr_valid, 1);
    checkOutput("rdf_instr_pc", instr_pc, 32'h100);

    // Redirect in HOLD with a same-cycle ack.
    cycle(1, 0, 0, 1, 1, 32'h200);
    checkOutput("rdh_valid_drop", instr_valid, 0);
    checkOutput("rdh_mem_req", mem_req, 1);
    checkOutput("rdh_mem_addr", mem_addr, 32'h200);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checkOutput("rdh_instr_pc", instr_pc, 32'h200);

    // Stall at ack time parks in IDLE; releasing it resumes sequentially.
    cycle(1, 1, 0, 1, 0, 0);
    checkOutput("stl_idle_req", mem_req, 0);
    checkOutput("stl_idle_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0, 0, 0);
      checkOutput("stl_hold_req", mem_req, 0);
    end
    cycle(1, 0, 0, 0, 0, 0);
    checkOutput("stl_resume_req", mem_req, 1);
    checkOutput("stl_resume_addr", mem_addr, 32'h204);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // PC wrap from the top word back to zero.
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 0, 0);
    checkOutput("wrp_mem_addr", mem_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checkOutput("wrp_instr_pc", instr_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 1, 0, 0);
    checkOutput("wrp_next_addr", mem_addr, 32'h0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    checkOutput("wrp_fetch_addr", mem_addr, 32'h4);

    // Asynchronous reset in the middle of a FETCH.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_mem_req", mem_req, 0);
    checkOutput("arst_mem_addr", mem_addr, 32'h0);
    checkOutput("arst_valid", instr_valid, 0);
    checkOutput("mid_sb_drained", expQ.size(), 0);
    doReset();

    // Redirect during LOAD: ir_load still pulses, HOLD is skipped.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    checkOutput("rdl_load", ir_load, 1);
    cycle(1, 0, 0, 0, 1, 32'h300);
    checkOutput("rdl_mem_req", mem_req, 1);
    checkOutput("rdl_mem_addr", mem_addr, 32'h300);
    checkOutput("rdl_no_valid", instr_valid, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checkOutput("rdl_still_fetch", mem_req, 1);
    checkOutput("end_sb_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
